// File: rtl/context_switch_ctrl_if.sv
// rtl/context_switch_ctrl_if.sv - data RAM bus between the context switch controller and the RAM
interface context_switch_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  mem_re;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/context_switch_ctrl.sv
// rtl/context_switch_ctrl.sv - round-robin time-slice context switcher saving/restoring slot PCs in data RAM
module context_switch_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_PROGRAMS = 4,
  parameter int QUANTUM      = 16,
  parameter int SLOT_STRIDE  = 200,
  localparam int SW          = $clog2(NUM_PROGRAMS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    instr_retired,
  input  logic [DATA_WIDTH-1:0]   pc_in,
  input  logic                    program_end,
  input  logic                    program_start,
  input  logic [SW-1:0]           start_slot,
  context_switch_ctrl_if.master   mem,
  output logic                    cpu_stall,
  output logic                    pc_load,
  output logic [DATA_WIDTH-1:0]   pc_value,
  output logic [SW-1:0]           current_program,
  output logic [NUM_PROGRAMS-1:0] active_mask
);
  localparam int CW = $clog2(QUANTUM) + 1;

  typedef enum logic [2:0] {S_RUN, S_SAVE, S_SELECT, S_LOAD_REQ, S_LOAD_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           slice_cnt;
  logic [DATA_WIDTH-1:0]   save_word;
  logic [DATA_WIDTH-1:0]   slot_base;
  logic [SW-1:0]           next_slot;
  logic [NUM_PROGRAMS-1:0] mask_nxt;
  logic                    trigger;

  assign slot_base = DATA_WIDTH'(current_program) * DATA_WIDTH'(SLOT_STRIDE);
  assign trigger   = (state == S_RUN) &&
                     (program_end || (enable && instr_retired && slice_cnt == CW'(QUANTUM - 1)));

  always_ff @(posedge clock) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:       if (trigger) state_nxt = S_SAVE;
      S_SAVE:      state_nxt = S_SELECT;
      S_SELECT:    state_nxt = S_LOAD_REQ;
      S_LOAD_REQ:  state_nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: state_nxt = S_RUN;
      default:     state_nxt = S_RUN;
    endcase
  end

  // Smallest offset wins; offset NUM_PROGRAMS (the current slot) is the fallback.
  always_comb begin
    next_slot = current_program;
    for (int i = NUM_PROGRAMS - 1; i >= 1; i--) begin
      if (active_mask[current_program + SW'(i)]) next_slot = current_program + SW'(i);
    end
  end

  // End beats start for the same slot; slot 0 is pinned runnable.
  always_comb begin
    mask_nxt = active_mask;
    if (program_start) mask_nxt[start_slot] = 1'b1;
    if (trigger && program_end) mask_nxt[current_program] = 1'b0;
    mask_nxt[0] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      current_program <= '0;
      active_mask     <= NUM_PROGRAMS'(1);
      slice_cnt       <= '0;
      save_word       <= '0;
    end else begin
      active_mask <= mask_nxt;
      if (trigger)
        save_word <= program_end ? '0 : pc_in - slot_base;
      else if (state == S_RUN && enable && instr_retired)
        slice_cnt <= slice_cnt + CW'(1);
      if (state == S_SELECT)    current_program <= next_slot;
      if (state == S_LOAD_WAIT) slice_cnt <= '0;
    end
  end

  always_comb begin
    mem.mem_we    = 1'b0;
    mem.mem_re    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    pc_load       = 1'b0;
    pc_value      = '0;
    cpu_stall     = 1'b0;
    case (state)
      S_SAVE: begin
        cpu_stall     = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = slot_base;
        mem.mem_wdata = save_word;
      end
      S_SELECT: cpu_stall = 1'b1;
      S_LOAD_REQ: begin
        cpu_stall    = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = slot_base;
      end
      S_LOAD_WAIT: begin
        cpu_stall = 1'b1;
        pc_load   = 1'b1;
        pc_value  = mem.mem_rdata + slot_base;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_context_switch_ctrl.sv
// tb/tb_context_switch_ctrl.sv - scoreboard bench for context_switch_ctrl against a slot-level reference model
module tb_context_switch_ctrl;
  localparam int DW = 32, NP = 4, Q = 4, STRIDE = 200;

  logic          clock = 1'b0;
  logic          reset, enable, instr_retired, program_end, program_start;
  logic [DW-1:0] pc_in;
  logic [1:0]    start_slot;
  logic          cpu_stall, pc_load;
  logic [DW-1:0] pc_value;
  logic [1:0]    current_program;
  logic [3:0]    active_mask;

  context_switch_ctrl_if #(.DATA_WIDTH(DW)) mem ();

  context_switch_ctrl #(.DATA_WIDTH(DW), .NUM_PROGRAMS(NP), .QUANTUM(Q), .SLOT_STRIDE(STRIDE)) dut (
    .clock(clock), .reset(reset), .enable(enable), .instr_retired(instr_retired),
    .pc_in(pc_in), .program_end(program_end), .program_start(program_start),
    .start_slot(start_slot), .mem(mem.master), .cpu_stall(cpu_stall), .pc_load(pc_load),
    .pc_value(pc_value), .current_program(current_program), .active_mask(active_mask)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // Data RAM: one word per slot region; unwritten words return their preload.
  logic [DW-1:0] ram_init [NP];
  logic [DW-1:0] ram      [NP];
  logic          written  [NP];
  initial for (int i = 0; i < NP; i++) written[i] = 1'b0;
  always @(posedge clock) begin
    if (mem.mem_we) begin
      ram[(mem.mem_addr / STRIDE) % NP]     <= mem.mem_wdata;
      written[(mem.mem_addr / STRIDE) % NP] <= 1'b1;
    end
    if (mem.mem_re)
      mem.mem_rdata <= written[(mem.mem_addr / STRIDE) % NP] ? ram[(mem.mem_addr / STRIDE) % NP]
                                                              : ram_init[(mem.mem_addr / STRIDE) % NP];
  end

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 pc_load
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  slot;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state
  int          m_phase;          // 0 running, 1..4 switch cycles
  logic [1:0]  m_cur;
  logic [3:0]  m_mask;
  int          m_cnt;
  logic [31:0] m_saved [NP];
  bit          m_valid = 0, m_after_reset = 0;
  logic [31:0] pc_drive = 0;

  function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] mask);
    for (int k = 1; k <= NP; k++)
      if (mask[(int'(cur) + k) % NP]) return 2'((int'(cur) + k) % NP);
    return cur;
  endfunction

  always @(negedge clock) begin
    if (mem.mem_we || mem.mem_re || pc_load) begin
      ev_t e;
      int act_kind;
      logic [31:0] act_data;
      checks++;
      if (int'(mem.mem_we) + int'(mem.mem_re) + int'(pc_load) != 1 || !cpu_stall) begin
        failures++;
        $display("FAIL strobe_excl we=%0b re=%0b pc_load=%0b stall=%0b required one strobe with stall=1",
                 mem.mem_we, mem.mem_re, pc_load, cpu_stall);
      end
      act_kind = mem.mem_we ? 0 : (mem.mem_re ? 1 : 2);
      act_data = mem.mem_we ? mem.mem_wdata : (pc_load ? pc_value : 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d addr=%0d data=%0d required no event", act_kind, mem.mem_addr, act_data);
      end else begin
        e = exp_q.pop_front();
        if (act_kind != e.kind || current_program != e.slot ||
            (e.kind != 2 && mem.mem_addr != e.addr) || (e.kind != 1 && act_data != e.data)) begin
          failures++;
          $display("FAIL event kind=%0d addr=%0d data=%0d slot=%0d required kind=%0d addr=%0d data=%0d slot=%0d",
                   act_kind, mem.mem_addr, act_data, current_program, e.kind, e.addr, e.data, e.slot);
        end
      end
    end
  end

  task automatic cycle(input bit r, input bit en, input bit ret, input bit pe, input bit ps, input logic [1:0] ss);
    logic [3:0] new_mask;
    logic [1:0] nxt;
    logic [31:0] rel;
    @(posedge clock);
    #1;
    reset = r; enable = en; instr_retired = ret; program_end = pe;
    program_start = ps; start_slot = ss; pc_in = pc_drive;
    @(negedge clock);
    #1;
    if (m_valid) begin
      checks++;
      if (cpu_stall !== (m_phase != 0) || active_mask !== m_mask || current_program !== m_cur) begin
        failures++;
        $display("FAIL state stall=%0b mask=%b cur=%0d required stall=%0b mask=%b cur=%0d",
                 cpu_stall, active_mask, current_program, m_phase != 0, m_mask, m_cur);
      end
    end
    if (m_after_reset) begin
      checks++;
      if ({mem.mem_we, mem.mem_re, pc_load} !== 3'b000 || mem.mem_addr !== 0 ||
          mem.mem_wdata !== 0 || pc_value !== 0) begin
        failures++;
        $display("FAIL after_reset we=%0b re=%0b pc_load=%0b addr=%0d wdata=%0d pc_value=%0d required all 0",
                 mem.mem_we, mem.mem_re, pc_load, mem.mem_addr, mem.mem_wdata, pc_value);
      end
    end
    if (r) begin
      exp_q.delete();
      m_phase = 0; m_cur = 0; m_mask = 4'b0001; m_cnt = 0;
      m_valid = 1; m_after_reset = 1;
      return;
    end
    m_after_reset = 0;
    new_mask = m_mask;
    if (ps && ss != 0) new_mask[ss] = 1'b1;
    case (m_phase)
      0: begin
        if (pe || (en && ret && m_cnt == Q - 1)) begin
          rel = pe ? 32'd0 : pc_drive - 32'(int'(m_cur) * STRIDE);
          exp_q.push_back('{0, 32'(int'(m_cur) * STRIDE), rel, m_cur});
          m_saved[m_cur] = rel;
          if (pe && m_cur != 0) new_mask[m_cur] = 1'b0;
          m_phase = 1;
        end else if (en && ret) m_cnt++;
      end
      2: begin
        nxt = rr_next(m_cur, m_mask);
        exp_q.push_back('{1, 32'(int'(nxt) * STRIDE), 32'd0, nxt});
        exp_q.push_back('{2, 32'd0, m_saved[nxt] + 32'(int'(nxt) * STRIDE), nxt});
        m_cur = nxt;
        m_phase = 3;
      end
      4: begin m_phase = 0; m_cnt = 0; end
      default: m_phase++;
    endcase
    m_mask = new_mask;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      ram_init[i] = (i == 2) ? 32'd5 : $urandom_range(0, 999);
      m_saved[i]  = ram_init[i];
    end
    m_phase = 0; m_cur = 0; m_mask = 4'b0001; m_cnt = 0;
    reset = 1; enable = 0; instr_retired = 0; program_end = 0; program_start = 0;
    start_slot = 0; pc_in = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Three retires stay inside the slice; slot 2 arrives; fourth retire switches.
    pc_drive = 37;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 2);
    cycle(0, 1, 1, 0, 0, 0);
    idle(6);
    // Slot 2 halts: saves 0, drops its mask bit, resumes slot 0.
    pc_drive = 460;
    cycle(0, 1, 0, 1, 0, 0);
    idle(6);
    // Round-robin wrap over slots 0,1,3.
    cycle(0, 1, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 1, 3);
    for (int s = 0; s < 5; s++) begin
      pc_drive = $urandom;
      for (int i = 0; i < Q; i++) cycle(0, 1, 1, 0, 0, 0);
      idle(5);
    end
    // Start and end of the running slot together; then retires with preemption disabled.
    cycle(0, 1, 0, 1, 1, current_program);
    idle(6);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0, 0);
    // Reset lands in the LOAD_REQ cycle.
    cycle(0, 1, 0, 0, 1, 2);
    cycle(0, 1, 0, 1, 0, 0);
    idle(2);
    cycle(1, 1, 0, 0, 0, 0);
    idle(2);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == 0) pc_drive = $urandom;
      cycle($urandom_range(0, 199) == 0, ($urandom % 8) != 0, $urandom % 2,
            $urandom_range(0, 29) == 0, ($urandom % 10) == 0, 2'($urandom % NP));
    end
    idle(8);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/context_switch_ctrl.md
CONTEXT_SWITCH_CTRL -- requirements
Module: context_switch_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and memory data.
REQ-002 SHALL have parameter NUM_PROGRAMS, default 4, number of program slots (power of two, >= 2); slot 0 is the resident shell.
REQ-003 SHALL have parameter QUANTUM, default 16, retired instructions per time slice.
REQ-004 SHALL have parameter SLOT_STRIDE, default 200, words per program region in data RAM.
REQ-005 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  time-slice preemption enable.
REQ-008 SHALL have port instr_retired  input  1  one pulse per retired CPU instruction.
REQ-009 SHALL have port pc_in  input  DATA_WIDTH  absolute PC of the running program.
REQ-010 SHALL have port program_end  input  1  running program executed its halt.
REQ-011 SHALL have port program_start  input  1  activate slot start_slot.
REQ-012 SHALL have port start_slot  input  log2(NUM_PROGRAMS)  slot to activate.
REQ-013 SHALL have port mem_rdata  input  DATA_WIDTH  data RAM read data, valid the cycle after mem_re.
REQ-014 SHALL have port mem_addr  output  DATA_WIDTH  data RAM absolute address.
REQ-015 SHALL have port mem_wdata  output  DATA_WIDTH  data RAM write data.
REQ-016 SHALL have port mem_we  output  1  write strobe, one cycle.
REQ-017 SHALL have port mem_re  output  1  read strobe, one cycle.
REQ-018 SHALL have port cpu_stall  output  1  CPU must hold while high.
REQ-019 SHALL have port pc_load  output  1  one-cycle pulse: CPU loads pc_value.
REQ-020 SHALL have port pc_value  output  DATA_WIDTH  absolute PC to resume.
REQ-021 SHALL have port current_program  output  log2(NUM_PROGRAMS)  running slot.
REQ-022 SHALL have port active_mask  output  NUM_PROGRAMS  bit i set = slot i runnable.

Function
REQ-023 SHALL implement FSM states RUN, SAVE, SELECT, LOAD_REQ, LOAD_WAIT, stepping one state per cycle outside RUN.
REQ-024 In RUN, SHALL increment an internal slice counter on each instr_retired while enable=1; counter holds while enable=0.
REQ-025 Trigger cycle T = RUN cycle with program_end=1, or with enable=1, instr_retired=1 and counter=QUANTUM-1.
REQ-026 SHALL be in SAVE at T+1, SELECT at T+2, LOAD_REQ at T+3, LOAD_WAIT at T+4, RUN at T+5; cpu_stall=1 exactly T+1..T+4.
REQ-027 SAVE: mem_we=1, mem_addr=current_program*SLOT_STRIDE, mem_wdata=pc_in-current_program*SLOT_STRIDE (slot-relative PC), or 0 if the trigger was program_end.
REQ-028 program_end at T SHALL clear active_mask[current_program] at T+1; program_end in slot 0 is ignored for the mask, but still forces a switch.
REQ-029 SELECT: next slot = first set active_mask bit searching current+1, current+2, ... modulo NUM_PROGRAMS, including current itself last; slot 0 always set, so search never fails.
REQ-030 LOAD_REQ: mem_re=1, mem_addr=next*SLOT_STRIDE; current_program SHALL update to next in this cycle.
REQ-031 LOAD_WAIT: pc_load=1, pc_value=mem_rdata+current_program*SLOT_STRIDE; slice counter cleared to 0.
REQ-032 A switch SHALL occur with uniform latency even when next equals current.
REQ-033 program_start SHALL set active_mask[start_slot] on the next edge in any state; start_slot=0 or already-set bit: no effect.
REQ-034 program_start and program_end for the same slot in the same cycle: end wins, bit cleared.
REQ-035 program_start in SELECT cycle SHALL be visible to that cycle's search only from the following switch.
REQ-036 instr_retired and program_end outside RUN SHALL be ignored.
REQ-037 Arithmetic SHALL be DATA_WIDTH unsigned, wrapping modulo 2^DATA_WIDTH.
REQ-038 mem_we, mem_re, pc_load SHALL never be high in the same cycle.

Reset
REQ-039 On reset: state RUN, current_program=0, active_mask=1 (slot 0 only), counter=0, mem_we=mem_re=pc_load=cpu_stall=0, mem_addr=mem_wdata=pc_value=0.
REQ-040 Reset in any state SHALL abort the switch at that edge with no further memory strobes.

Verification (QUANTUM=4, NUM_PROGRAMS=4, SLOT_STRIDE=200)
REQ-041 Reset, 3 instr_retired pulses -> no switch, cpu_stall=0, current_program=0.
REQ-042 Start slot 2; 4 retires in slot 0 with pc_in=37 -> write addr 0 data 37; read addr 400; mem_rdata=5 -> pc_load with pc_value=405, current_program=2.
REQ-043 In slot 2, pc_in=460, program_end -> write addr 400 data 0, active_mask=0001, resumes slot 0 with pc_value=mem_rdata.
REQ-044 Slots 1,3 active, running 3 -> next is 0, then 1, then 3 (round-robin wrap).
REQ-045 program_start and program_end same slot same cycle -> bit cleared; enable=0 with 20 retires -> no switch.
REQ-046 Reset asserted during LOAD_REQ -> next cycle all strobes 0, current_program=0, active_mask=0001.
